result_bcd_converter: RTL and testbench

//  Converts one binary matrix-multiply result word to packed BCD digits for the digit_8x16

---
 rtl/vga_disp_pkg.sv | 12 +
 rtl/result_bcd_converter_if.sv | 23 ++
 rtl/result_bcd_converter_bcd_add3.sv | 7 +
 rtl/result_bcd_converter.sv | 116 +++++++++++
 tb/tb_result_bcd_converter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_disp_pkg.sv
// Shared constants and FSM encoding for the VGA result display path.
package vga_disp_pkg;
  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] BCD_NINE   = 4'h9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } conv_state_e;
endpackage

// File: rtl/result_bcd_converter_if.sv
// Word-in / digits-out bundle between the result source and the BCD converter.
interface result_bcd_converter_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      in_data;
  logic                  vblank;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf_out;
  logic                  frame_upd;

  modport master (
    output in_valid, in_data, vblank,
    input  in_ready, bcd_out, ovf_out, frame_upd
  );

  modport slave (
    input  in_valid, in_data, vblank,
    output in_ready, bcd_out, ovf_out, frame_upd
  );
endinterface

// File: rtl/result_bcd_converter_bcd_add3.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more before the shift.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/result_bcd_converter.sv
// Sequential binary->BCD converter whose result is committed only on a vblank rising edge.
// Optional leading-zero blanking: define RESULT_BCD_LZ_BLANK_EN.
module result_bcd_converter
  import vga_disp_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input logic                  clk,
  input logic                  reset,
  result_bcd_converter_if.slave bus
);
  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_e        state, state_nx;
  logic [BIN_W-1:0]   bin_sh;
  logic [BCD_W-1:0]   bcd_sh, bcd_adj, commit_val;
  logic [CNT_W-1:0]   cnt;
  logic               ovf, vblank_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q, upd_q;
  logic               accept, vb_rise, commit;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d(bcd_sh[g*DIGIT_W +: DIGIT_W]),
      .q(bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.bcd_out   = bcd_q;
  assign bus.ovf_out   = ovf_q;
  assign bus.frame_upd = upd_q;

  assign accept  = bus.in_valid && (state == IDLE);
  assign vb_rise = bus.vblank && !vblank_q;
  assign commit  = (state == HOLD) && vb_rise;

`ifdef RESULT_BCD_LZ_BLANK_EN
  logic lead;
`endif

  always_comb begin
    commit_val = bcd_sh;
`ifdef RESULT_BCD_LZ_BLANK_EN
    lead = 1'b1;
`endif
    if (ovf) begin
      commit_val = {DIGITS{BCD_NINE}};
    end
`ifdef RESULT_BCD_LZ_BLANK_EN
    else begin
      // ones digit is never blanked so a value of 0 still shows '0'
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (lead && (bcd_sh[i*DIGIT_W +: DIGIT_W] == 4'd0))
          commit_val[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
        else
          lead = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)          state_nx = SHIFT;
      SHIFT:   if (cnt == '0)       state_nx = HOLD;
      HOLD:    if (vb_rise)         state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_sh   <= '0;
      bcd_sh   <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      vblank_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      vblank_q <= bus.vblank;
      upd_q    <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          bin_sh <= bus.in_data;
          bcd_sh <= '0;
          ovf    <= 1'b0;
          cnt    <= CNT_W'(BIN_W - 1);
        end
        SHIFT: begin
          // the bit leaving the top digit means the value no longer fits
          {bcd_sh, bin_sh} <= {bcd_adj[BCD_W-2:0], bin_sh, 1'b0};
          ovf              <= ovf | bcd_adj[BCD_W-1];
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        HOLD: if (commit) begin
          bcd_q <= commit_val;
          ovf_q <= ovf;
          upd_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed bench: 5-digit and 4-digit converters share stimulus, expected digits hand-computed.
module tb_result_bcd_converter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        vblank = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  result_bcd_converter_if #(.BIN_W(16), .DIGITS(5)) bus5 ();
  result_bcd_converter_if #(.BIN_W(16), .DIGITS(4)) bus4 ();

  assign bus5.in_valid = in_valid;
  assign bus5.in_data  = in_data;
  assign bus5.vblank   = vblank;
  assign bus4.in_valid = in_valid;
  assign bus4.in_data  = in_data;
  assign bus4.vblank   = vblank;

  result_bcd_converter #(.BIN_W(16), .DIGITS(5)) dut5 (.clk(clk), .reset(reset), .bus(bus5));
  result_bcd_converter #(.BIN_W(16), .DIGITS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  typedef struct {
    logic [15:0] data;
    logic [19:0] e5;
    logic [19:0] e5lz;
    logic [15:0] e4;
    logic [15:0] e4lz;
    logic        o4;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] sel5(input logic [19:0] plain, input logic [19:0] lz);
`ifdef RESULT_BCD_LZ_BLANK_EN
    return lz;
`else
    return plain;
`endif
  endfunction

  function automatic logic [15:0] sel4(input logic [15:0] plain, input logic [15:0] lz);
`ifdef RESULT_BCD_LZ_BLANK_EN
    return lz;
`else
    return plain;
`endif
  endfunction

  task automatic send(input logic [15:0] d);
    int k = 0;
    while (!bus5.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_send", 32'(bus5.in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_commit(input string name, input logic [19:0] e5, input logic [15:0] e4,
                               input logic o4);
    check({name, "_upd5"}, 32'(bus5.frame_upd), 32'd1);
    check({name, "_upd4"}, 32'(bus4.frame_upd), 32'd1);
    check({name, "_bcd5"}, 32'(bus5.bcd_out), 32'(e5));
    check({name, "_ovf5"}, 32'(bus5.ovf_out), 32'd0);
    check({name, "_bcd4"}, 32'(bus4.bcd_out), 32'(e4));
    check({name, "_ovf4"}, 32'(bus4.ovf_out), 32'(o4));
    @(negedge clk);
    check({name, "_upd_pulse"}, 32'({bus5.frame_upd, bus4.frame_upd}), 32'd0);
    check({name, "_hold_bcd"}, 32'(bus5.bcd_out), 32'(e5));
    check({name, "_ready_after"}, 32'(bus5.in_ready), 32'd1);
  endtask

  initial begin
    logic ok;
    vecs[0] = '{16'd0,     20'h00000, 20'hFFFF0, 16'h0000, 16'hFFF0, 1'b0};
    vecs[1] = '{16'd7,     20'h00007, 20'hFFFF7, 16'h0007, 16'hFFF7, 1'b0};
    vecs[2] = '{16'd1234,  20'h01234, 20'hF1234, 16'h1234, 16'h1234, 1'b0};
    vecs[3] = '{16'd42,    20'h00042, 20'hFFF42, 16'h0042, 16'hFF42, 1'b0};
    vecs[4] = '{16'd99,    20'h00099, 20'hFFF99, 16'h0099, 16'hFF99, 1'b0};
    vecs[5] = '{16'd10000, 20'h10000, 20'h10000, 16'h9999, 16'h9999, 1'b1};
    vecs[6] = '{16'd9,     20'h00009, 20'hFFFF9, 16'h0009, 16'hFFF9, 1'b0};
    vecs[7] = '{16'd100,   20'h00100, 20'hFF100, 16'h0100, 16'hF100, 1'b0};
    vecs[8] = '{16'd65535, 20'h65535, 20'h65535, 16'h9999, 16'h9999, 1'b1};

    #1;
    check("rst_bcd", 32'(bus5.bcd_out), 32'd0);
    check("rst_ovf", 32'(bus4.ovf_out), 32'd0);
    check("rst_upd", 32'(bus5.frame_upd), 32'd0);
    check("rst_ready", 32'(bus5.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // table: convert, stay busy through a long vblank-low wait, commit on the rise
    foreach (vecs[i]) begin
      send(vecs[i].data);
      ok = 1'b1;
      repeat (40) begin
        if (bus5.in_ready || bus4.in_ready || bus5.frame_upd || bus4.frame_upd) ok = 1'b0;
        @(negedge clk);
      end
      check($sformatf("busy_%0d", vecs[i].data), 32'(ok), 32'd1);
      vblank = 1'b1;
      @(negedge clk);
      expect_commit($sformatf("vec_%0d", vecs[i].data), sel5(vecs[i].e5, vecs[i].e5lz),
                    sel4(vecs[i].e4, vecs[i].e4lz), vecs[i].o4);
      vblank = 1'b0;
      repeat (2) @(negedge clk);
    end

    // vblank already high at HOLD entry, plus a word offered during HOLD
    vblank = 1'b1;
    repeat (2) @(negedge clk);
    send(16'd321);
    ok = 1'b1;
    repeat (20) begin
      if (bus5.frame_upd || bus4.frame_upd) ok = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = 16'd777;
    repeat (5) begin
      if (bus5.frame_upd || bus5.in_ready) ok = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("vb_high_no_commit", 32'(ok), 32'd1);
    check("vb_high_bcd_kept", 32'(bus5.bcd_out), 32'(sel5(20'h65535, 20'h65535)));
    vblank = 1'b0;
    repeat (3) @(negedge clk);
    vblank = 1'b1;
    @(negedge clk);
    expect_commit("vb_high", sel5(20'h00321, 20'hFF321), sel4(16'h0321, 16'hF321), 1'b0);
    vblank = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_word_dropped", 32'(bus5.bcd_out), 32'(sel5(20'h00321, 20'hFF321)));

    // rise lands in the cycle of the final shift: must wait for the next rise
    send(16'd88);
    repeat (15) @(negedge clk);
    vblank = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      if (bus5.frame_upd || bus4.frame_upd) ok = 1'b0;
      @(negedge clk);
    end
    check("late_edge_ignored", 32'(ok), 32'd1);
    vblank = 1'b0;
    repeat (2) @(negedge clk);
    vblank = 1'b1;
    @(negedge clk);
    expect_commit("late_edge", sel5(20'h00088, 20'hFFF88), sel4(16'h0088, 16'hFF88), 1'b0);
    vblank = 1'b0;
    repeat (2) @(negedge clk);

    // leave an overflow committed on dut4, then reset in the middle of a conversion
    send(16'd65535);
    repeat (20) @(negedge clk);
    vblank = 1'b1;
    @(negedge clk);
    vblank = 1'b0;
    check("pre_rst_ovf4", 32'(bus4.ovf_out), 32'd1);
    send(16'd555);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_bcd5", 32'(bus5.bcd_out), 32'd0);
    check("mid_rst_bcd4", 32'(bus4.bcd_out), 32'd0);
    check("mid_rst_ovf4", 32'(bus4.ovf_out), 32'd0);
    check("mid_rst_ready", 32'(bus5.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 32'({bus5.in_ready, bus5.frame_upd}), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
